a_emission_rs232: RTL and testbench
===================================

Name: a_emission_rs232

Overview:
- RS232 transmitter for the auto-baud UART core.
- Serialises one byte per handshake onto the TX line at the baud rate that the receive-side measurement block (a_calcul_freq) derived from the incoming start bit.
- Takes the measured divider (div_freq_rec), the prescaler setting (val_div) and the measurement-done flag (flag_first) directly from that block.
- Sits beside the receiver in the RS232 core; the byte-side handshake faces the management logic.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk_ref  in  1  reference clock.
- rst_n  in  1  asynchronous reset, active low.
- div_freq  in  12  measured bit length, in prescaler ticks.
- val_div  in  4  prescaler terminal count; one tick = val_div+1 clk_ref cycles.
- flag_first  in  1  high once the baud measurement is complete and valid.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- tx_busy  out  1  a frame is in progress.
- tx_done  out  1  one-cycle pulse at the end of a frame.
- t_do  out  1  serial TX line; idle level is high.

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-frame: t_do=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, all counters 0. A frame interrupted by reset is lost.
- Bit period: B = (val_div+1)*div_freq clk_ref cycles. div_freq and val_div are sampled into internal registers at byte acceptance. Input changes during a frame have no effect until the next acceptance.
- tx_ready is registered. It is 1 only when all of these hold: state=IDLE, flag_first=1, div_freq!=0. div_freq=0 or flag_first=0 keeps the block idle with t_do=1.
- Accept: tx_valid && tx_ready at a rising edge. At that edge tx_data is latched, tx_ready goes 0, tx_busy goes 1, and t_do goes 0 (start bit). tx_valid while tx_ready=0 is ignored; the source holds the byte.
- States:
  - IDLE -> START on accept.
  - START -> DATA after B cycles.
  - DATA: DATA_BITS bits, LSB first, B cycles each. Then -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: one bit of B cycles. Value is the XOR of the data bits, inverted when PARITY_ODD. -> STOP.
  - STOP: t_do=1 for STOP_BITS*B cycles, then -> IDLE.
- Frame length on t_do: exactly F*B cycles, where F = 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- tx_done is high exactly in the last cycle of the final stop bit. In that same cycle tx_busy drops on the next edge.
- tx_ready reasserts one cycle after tx_done. The earliest next start bit therefore follows the stop bit after exactly 1 extra idle-high cycle.
- Counters:
  - 4-bit prescaler counts 0..val_div_latched, then wraps to 0 and emits a tick.
  - 12-bit tick counter counts ticks 1..div_freq_latched per bit; at terminal count it advances the bit and resets to 0.
  - Bit index counter runs 0..DATA_BITS-1. Stop-bit counter runs 0..STOP_BITS-1.
  - No counter ever wraps silently.
- val_div=0 gives a tick every cycle, so B = div_freq cycles. The minimum legal B is 1 cycle (val_div=0, div_freq=1), and the frame must still be correct at B=1.
- t_do is driven from a register with no combinational path from any input.

Decomposition:
- Package rs232_pkg holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - widths DIV_W=12 and PRESC_W=4;
  - the frame-length function F(DATA_BITS, PARITY_EN, STOP_BITS).
- One sub-module, a_baud_tick_tx, contains the prescaler plus tick counter. It has load/clear inputs and outputs a bit_end pulse. The receive side may reuse it later.

Test Plan:
- val_div=3, div_freq=4 (B=16), 8N1, send 0x55 -> t_do: 0 for 16 cycles; then 1,0,1,0,1,0,1,0 at 16 cycles each; then 1 for 16 cycles. tx_done is high at cycle 159 after accept. tx_ready returns at cycle 160.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1, the parity bit is 0. Frame is 11*B cycles.
- flag_first=0, or div_freq=0 with flag_first=1, while tx_valid=1 -> tx_ready stays 0, t_do stays 1, no tx_done.
- Accept 0xA3 with div_freq=4, then change div_freq to 9 mid-frame -> the frame completes at B=16. The next byte uses B=(3+1)*9=36.
- Assert rst_n=0 during data bit 3 -> t_do=1 immediately (asynchronous), tx_busy=0. After release, a new byte transmits a correct full frame.
- Loopback: feed t_do into the receive-side measurement block with val_div=0, div_freq=1 (B=1), STOP_BITS=2, and run back-to-back bytes 0x00 and 0xFF -> the received bytes match and there is exactly 1 idle cycle between frames.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit path: state encoding, counter widths
// and frame arithmetic helpers.
package rs232_pkg;

    localparam int DIV_W   = 12;
    localparam int PRESC_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Number of bit periods in one frame on the line.
    function automatic int frame_len(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

    // Unused upper bits must be zero; they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/a_baud_tick_tx.sv
// Bit-period timer: prescaler (val_div+1 cycles per tick) followed by a tick
// counter (div_freq ticks per bit). bit_end_o marks the last cycle of a bit.
module a_baud_tick_tx
    import rs232_pkg::*;
(
    input  logic               clk_ref,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [DIV_W-1:0]   div_freq_i,
    input  logic [PRESC_W-1:0] val_div_i,
    output logic               bit_end_o
);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [PRESC_W-1:0] val_q, val_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               tick_s;
    logic               bit_end_s;

    // Terminal tests use >= so neither counter can run past its limit and wrap.
    assign tick_s    = (presc_q >= val_q);
    assign bit_end_s = tick_s && (({1'b0, tick_cnt_q} + 13'd1) >= {1'b0, div_q});
    assign bit_end_o = bit_end_s && !clear_i;

    // Next-state for the latched divider settings and both counters.
    always_comb begin
        div_d      = div_q;
        val_d      = val_q;
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;
        if (load_i) begin
            div_d = div_freq_i;
            val_d = val_div_i;
        end else begin
            div_d = div_q;
            val_d = val_q;
        end
        if (clear_i) begin
            presc_d    = {PRESC_W{1'b0}};
            tick_cnt_d = {DIV_W{1'b0}};
        end else if (tick_s) begin
            presc_d    = {PRESC_W{1'b0}};
            tick_cnt_d = bit_end_s ? {DIV_W{1'b0}} : (tick_cnt_q + 12'd1);
        end else begin
            presc_d    = presc_q + 4'd1;
        end
    end

    // Counter and settings registers.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= {DIV_W{1'b0}};
            val_q      <= {PRESC_W{1'b0}};
            presc_q    <= {PRESC_W{1'b0}};
            tick_cnt_q <= {DIV_W{1'b0}};
        end else begin
            div_q      <= div_d;
            val_q      <= val_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/a_emission_rs232.sv
// RS232 transmitter: serialises one byte per handshake at the baud rate measured
// by the receive side; start, LSB-first data, optional parity, stop bit(s).
module a_emission_rs232
    import rs232_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_ref,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     div_freq,
    input  logic [PRESC_W-1:0]   val_div,
    input  logic                 flag_first,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 t_do
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 t_do_q, t_do_d;
    logic                 ready_q, ready_d;
    logic                 accept_s;
    logic                 bit_end_s;
    logic                 last_stop_s;

    assign accept_s    = tx_valid && ready_q;
    assign last_stop_s = (stop_idx_q == 1'(STOP_BITS - 1));

    a_baud_tick_tx u_tick (
        .clk_ref    (clk_ref),
        .rst_n      (rst_n),
        .load_i     (accept_s),
        .clear_i    (state_q == ST_IDLE),
        .div_freq_i (div_freq),
        .val_div_i  (val_div),
        .bit_end_o  (bit_end_s)
    );

    // State register and frame bookkeeping.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= {IDX_W{1'b0}};
            stop_idx_q <= 1'b0;
            data_q     <= {DATA_BITS{1'b0}};
            t_do_q     <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            t_do_q     <= t_do_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state: every transition except acceptance waits for the end of a bit.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_START;
                    data_d     = tx_data;
                    bit_idx_d  = {IDX_W{1'b0}};
                    stop_idx_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = {IDX_W{1'b0}};
                end else begin
                    state_d   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_q == IDX_W'(DATA_BITS - 1))) begin
                    state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    stop_idx_d = 1'b0;
                end else if (bit_end_s) begin
                    bit_idx_d  = bit_idx_q + 1'b1;
                end else begin
                    state_d    = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end else begin
                    state_d    = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && last_stop_s) begin
                    state_d    = ST_IDLE;
                end else if (bit_end_s) begin
                    stop_idx_d = stop_idx_q + 1'b1;
                end else begin
                    state_d    = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level and readiness are decoded from the next state so both leave a flop.
    always_comb begin
        t_do_d = 1'b1;
        case (state_d)
            ST_IDLE:   t_do_d = 1'b1;
            ST_START:  t_do_d = 1'b0;
            ST_DATA:   t_do_d = data_d[bit_idx_d];
            ST_PARITY: t_do_d = parity_bit(8'(data_d), 1'(PARITY_ODD));
            ST_STOP:   t_do_d = 1'b1;
            default:   t_do_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE) && flag_first && (div_freq != 12'd0);
    end

    assign t_do     = t_do_q;
    assign tx_ready = ready_q;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = (state_q == ST_STOP) && last_stop_s && bit_end_s;

endmodule

// File: tb/tb_a_emission_rs232.sv
// Bench for a_emission_rs232: three configurations (8N1, 8E1, 7O2) against a
// frame-level model of the expected line waveform and handshake.
module tb_a_emission_rs232;

    logic        clk_ref    = 1'b0;
    logic        rst_n      = 1'b0;
    logic [11:0] div_freq   = 12'd0;
    logic [3:0]  val_div    = 4'd0;
    logic        flag_first = 1'b0;
    logic [7:0]  dat [3];
    logic [2:0]  vld = 3'b000;
    logic [2:0]  rdy, busy, done, tdo;

    always #5 clk_ref = ~clk_ref;

    a_emission_rs232 u_dut0 (
        .clk_ref(clk_ref), .rst_n(rst_n), .div_freq(div_freq), .val_div(val_div),
        .flag_first(flag_first), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_busy(busy[0]), .tx_done(done[0]), .t_do(tdo[0]));

    a_emission_rs232 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk_ref(clk_ref), .rst_n(rst_n), .div_freq(div_freq), .val_div(val_div),
        .flag_first(flag_first), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_busy(busy[1]), .tx_done(done[1]), .t_do(tdo[1]));

    a_emission_rs232 #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk_ref(clk_ref), .rst_n(rst_n), .div_freq(div_freq), .val_div(val_div),
        .flag_first(flag_first), .tx_data(dat[2][6:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_busy(busy[2]), .tx_done(done[2]), .t_do(tdo[2]));

    // Model: frame as a list of line levels, each held for B cycles.
    int          m_db [3] = '{8, 8, 7};
    int          m_pe [3] = '{0, 1, 1};
    int          m_po [3] = '{0, 0, 1};
    int          m_sb [3] = '{1, 1, 2};
    bit          m_act [3] = '{default: 1'b0};
    bit          m_rdy [3] = '{default: 1'b0};
    int          m_cnt [3] = '{default: 0};
    int          m_b   [3] = '{default: 1};
    logic [11:0] m_bits [3];
    int          acc_cnt [3] = '{default: 0};
    int          acc_cyc [3] = '{default: 0};
    int          cyc_no = 0;
    bit          cmp_en = 1'b0;
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic int flen(input int i);
        return 1 + m_db[i] + m_pe[i] + m_sb[i];
    endfunction

    function automatic logic [11:0] frame_bits(input int i, input logic [7:0] d);
        logic [11:0] b;
        logic        par;
        b    = 12'hFFF;
        b[0] = 1'b0;
        par  = (m_po[i] != 0);
        for (int k = 0; k < m_db[i]; k++) begin
            b[1 + k] = d[k];
            par      = par ^ d[k];
        end
        if (m_pe[i] != 0) b[1 + m_db[i]] = par;
        return b;
    endfunction

    task automatic model_step();
        bit acc;
        cyc_no++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_act[i] = 1'b0;
                m_rdy[i] = 1'b0;
                m_cnt[i] = 0;
            end else begin
                acc = !m_act[i] && m_rdy[i] && vld[i];
                if (m_act[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == flen(i) * m_b[i]) m_act[i] = 1'b0;
                end
                if (acc) begin
                    m_act[i]  = 1'b1;
                    m_cnt[i]  = 0;
                    m_b[i]    = (int'(val_div) + 1) * int'(div_freq);
                    m_bits[i] = frame_bits(i, dat[i]);
                    acc_cnt[i]++;
                    acc_cyc[i] = cyc_no;
                end
                m_rdy[i] = !m_act[i] && flag_first && (div_freq != 12'd0);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_ref);
        #2;
    endtask

    task automatic wait_acc(input int i, input int c0, input int lim);
        int n;
        n = 0;
        while (acc_cnt[i] == c0 && n < lim) begin
            step(1);
            n++;
        end
        chk($sformatf("accept_timeout%0d", i), 32'(acc_cnt[i] != c0), 32'd1);
    endtask

    initial forever begin
        @(posedge clk_ref);
        model_step();
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk_ref);
        if (cmp_en && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(m_rdy[i]));
                chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_act[i]));
                chk($sformatf("done%0d", i), 32'(done[i]),
                    32'(m_act[i] && (m_cnt[i] == flen(i) * m_b[i] - 1)));
                chk($sformatf("tdo%0d", i), 32'(tdo[i]),
                    32'(m_act[i] ? m_bits[i][m_cnt[i] / m_b[i]] : 1'b1));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a1, a2;
        int seen [3];
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        step(3);
        chk("rst_tdo", 32'(tdo), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(rdy), 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // 8N1, B=16, 0x55
        flag_first = 1'b1; div_freq = 12'd4; val_div = 4'd3;
        step(2);
        chk("ready_up", 32'(rdy[0]), 32'd1);
        dat[0] = 8'h55; vld[0] = 1'b1;
        step(1);
        vld[0] = 1'b0;
        for (int k = 0; k <= 160; k++) begin
            if (k == 0 || k == 15) chk("s55_start", 32'(tdo[0]), 32'd0);
            if (k == 16)  chk("s55_bit0", 32'(tdo[0]), 32'd1);
            if (k == 32)  chk("s55_bit1", 32'(tdo[0]), 32'd0);
            if (k == 143) chk("s55_bit7", 32'(tdo[0]), 32'd0);
            if (k == 144) chk("s55_stop", 32'(tdo[0]), 32'd1);
            if (k == 158) chk("s55_done_early", 32'(done[0]), 32'd0);
            if (k == 159) begin
                chk("s55_done", 32'(done[0]), 32'd1);
                chk("s55_ready159", 32'(rdy[0]), 32'd0);
                chk("s55_busy159", 32'(busy[0]), 32'd1);
            end
            if (k == 160) begin
                chk("s55_ready160", 32'(rdy[0]), 32'd1);
                chk("s55_busy160", 32'(busy[0]), 32'd0);
            end
            if (k < 160) step(1);
        end

        // Parity: 0x07 even -> 1, odd (7 bits) -> 0, both frames 11*B
        val_div = 4'd0; div_freq = 12'd2;
        step(2);
        dat[1] = 8'h07; dat[2] = 8'h07; vld[1] = 1'b1; vld[2] = 1'b1;
        step(1);
        vld = 3'b000;
        for (int k = 0; k <= 22; k++) begin
            if (k == 18) chk("par_even", 32'(tdo[1]), 32'd1);
            if (k == 16) chk("par_odd", 32'(tdo[2]), 32'd0);
            if (k == 21) chk("par_done", 32'(done[2:1]), 32'h3);
            if (k < 22) step(1);
        end

        // No measurement / zero divider: stay idle
        flag_first = 1'b0;
        step(2);
        vld = 3'b111;
        step(20);
        chk("noflag_ready", 32'(rdy), 32'h0);
        chk("noflag_tdo", 32'(tdo), 32'h7);
        flag_first = 1'b1; div_freq = 12'd0;
        step(20);
        chk("div0_ready", 32'(rdy), 32'h0);
        chk("div0_busy", 32'(busy), 32'h0);
        vld = 3'b000; div_freq = 12'd4; val_div = 4'd3;
        step(2);

        // Divider change mid-frame only affects the next byte
        dat[0] = 8'hA3; vld[0] = 1'b1;
        step(1);
        vld[0] = 1'b0;
        step(40);
        div_freq = 12'd9;
        step(119);
        chk("a3_done_b16", 32'(done[0]), 32'd1);
        step(1);
        dat[0] = 8'h3C; vld[0] = 1'b1;
        step(1);
        vld[0] = 1'b0;
        step(359);
        chk("next_done_b36", 32'(done[0]), 32'd1);
        step(1);

        // Asynchronous reset during data bit 3
        div_freq = 12'd4;
        step(1);
        dat[0] = 8'hC5; vld[0] = 1'b1;
        step(1);
        vld[0] = 1'b0;
        step(70);
        chk("pre_rst_bit3", 32'(tdo[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_tdo", 32'(tdo[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        dat[0] = 8'h96; vld[0] = 1'b1; c0 = acc_cnt[0];
        wait_acc(0, c0, 10);
        vld[0] = 1'b0;
        step(159);
        chk("post_rst_done", 32'(done[0]), 32'd1);
        step(2);

        // B=1, 7O2 back-to-back 0x00 then 0xFF: one idle cycle between frames
        val_div = 4'd0; div_freq = 12'd1;
        step(2);
        dat[2] = 8'h00; vld[2] = 1'b1; c0 = acc_cnt[2];
        wait_acc(2, c0, 20);
        a1 = acc_cyc[2];
        dat[2] = 8'hFF;
        wait_acc(2, c0 + 1, 40);
        a2 = acc_cyc[2];
        vld[2] = 1'b0;
        chk("b2b_gap", 32'(a2 - a1), 32'd12);
        step(8);
        chk("b2b_ff_parity", 32'(tdo[2]), 32'd0);
        step(2);
        chk("b2b_done", 32'(done[2]), 32'd1);
        step(3);

        // Randomised traffic
        for (int i = 0; i < 3; i++) seen[i] = acc_cnt[i];
        for (int r = 0; r < 2500; r++) begin
            if (r % 64 == 0) begin
                val_div    = 4'($urandom_range(0, 3));
                div_freq   = 12'($urandom_range(1, 5));
                flag_first = ($urandom_range(0, 7) != 0);
            end
            for (int i = 0; i < 3; i++) begin
                if (acc_cnt[i] != seen[i]) begin
                    seen[i] = acc_cnt[i];
                    vld[i]  = 1'($urandom_range(0, 1));
                    dat[i]  = 8'($urandom);
                end else if (!vld[i] && $urandom_range(0, 3) == 0) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end
            end
            step(1);
        end
        vld = 3'b000; flag_first = 1'b1;
        step(300);
        chk("final_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
